lix_shr_rx: RTL

Receive end of the enable-gated data pipelines (N-stage register chains with a shared stall enable and no output valid). It drives the pipeline enable, rebuilds the per-word valid from a shadow of issue valids, and captures each pipeline result into a D-entry output buffer. The buffer drains through a standard valid/ready handshake. It sits between every `lix` arithmetic/masking pipeline tail and the next stream consumer.

---
 rtl/lix_pkg.sv | 14 +
 rtl/lix_fifo_sc.sv | 58 +++++
 rtl/lix_reg.sv | 26 ++
 rtl/lix_shr_rx.sv | 64 ++++++
 4 files changed

// File: rtl/lix_pkg.sv
// Shared sizing helpers for the lix pipeline-tail blocks.
package lix_pkg;

  localparam int unsigned LIX_PTR_W_MIN = 1;

  function automatic int unsigned LIX_CNT_W(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

  function automatic int unsigned LIX_PTR_W(input int unsigned d);
    return (d > 1) ? $clog2(d) : LIX_PTR_W_MIN;
  endfunction

endpackage

// File: rtl/lix_fifo_sc.sv
// Single-clock circular FIFO with occupancy count; push+pop at full is legal.
module lix_fifo_sc
  import lix_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned D = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            wdata_i,
  output logic [W-1:0]            rdata_o,
  output logic [LIX_CNT_W(D)-1:0] cnt_o
);

  localparam int unsigned PW = LIX_PTR_W(D);
  localparam int unsigned CW = LIX_CNT_W(D);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // D is a power of two, so pointer overflow is the modulo-D wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/lix_reg.sv
// Enable-gated register stage with synchronous clear.
module lix_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/lix_shr_rx.sv
// Receive end of an enable-gated pipeline: drives the stall enable, tracks
// issue valids in a shadow chain and captures tail words into an output FIFO.
module lix_shr_rx
  import lix_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 2,
  parameter int unsigned D = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_vld,
  input  logic [W-1:0]            i_z,
  input  logic                    i_flush,
  output logic                    o_en,
  output logic                    o_vld,
  output logic [W-1:0]            o_z,
  input  logic                    i_rdy,
  output logic [LIX_CNT_W(D)-1:0] o_cnt,
  output logic                    o_busy
);

  localparam int unsigned CW = LIX_CNT_W(D);
  localparam logic [CW-1:0] CNT_FULL = CW'(D);

  logic         clr;
  logic [N:0]   s;
  logic         push;
  logic         pop;
  logic [CW-1:0] cnt;

  assign clr  = rst_i | i_flush;
  assign s[0] = i_vld;

  for (genvar k = 0; k < N; k++) begin : g_shadow
    lix_reg #(.W(1)) u_stage (
      .clk_i (clk_i),
      .rst_i (clr),
      .en_i  (o_en),
      .d_i   (s[k]),
      .q_o   (s[k+1])
    );
  end

  // Capture on the edge that overwrites the tail, so each word lands once.
  assign o_vld = (cnt != '0);
  assign pop   = o_vld & i_rdy;
  assign o_en  = (cnt != CNT_FULL) | pop;
  assign push  = s[N] & o_en;

  lix_fifo_sc #(.W(W), .D(D)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (i_z),
    .rdata_o (o_z),
    .cnt_o   (cnt)
  );

  assign o_cnt  = cnt;
  assign o_busy = (|s[N:1]) | o_vld;

endmodule
